// File: rtl/win3_pkg.sv
// Shared constants, FSM state encoding and window slot helpers for the 3x3 window generator.
package win3_pkg;

  localparam int PIX_W       = 8;
  localparam int WIN_N       = 9;
  localparam int WIN_DIM     = 3;
  localparam int SLOT_TL     = 0;
  localparam int SLOT_CENTRE = 4;
  localparam int SLOT_BR     = 8;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    STREAM,
    FLUSH,
    DONE
  } state_t;

  // Row-major slot index inside the flattened window.
  function automatic int slot_idx(input int row, input int col);
    return row * WIN_DIM + col;
  endfunction

endpackage

// File: rtl/win3_line_buf.sv
// One-line pixel store: combinational read, write on clock edge, so a same-cycle read returns the old word.
// No flow control of its own; the caller gates wr_en with its accept strobe.
module win3_line_buf #(
  parameter int PIX_W = 8,
  parameter int DEPTH = 512,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [PIX_W-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [PIX_W-1:0] rd_data
);
  import win3_pkg::*;

  logic [PIX_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/window_3x3_gen.sv
// Raster 3x3 window generator: one window per pixel, registered out, W+1 pixel fill latency; stalls input when out is held.
// Optional WIN3_FRAME_MARKERS_EN adds out_sof/out_eol/out_eof registered alongside out_win.
module window_3x3_gen #(
  parameter int PIX_W      = win3_pkg::PIX_W,
  parameter int MAX_WIDTH  = 512,
  parameter int MAX_HEIGHT = 512,
  parameter int DIM_W      = $clog2((MAX_WIDTH > MAX_HEIGHT) ? MAX_WIDTH + 1 : MAX_HEIGHT + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [DIM_W-1:0]   cfg_width,
  input  logic [DIM_W-1:0]   cfg_height,
  output logic               cfg_err,
  output logic               busy,
  output logic               frame_done,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PIX_W-1:0]   in_pix,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [9*PIX_W-1:0] out_win,
  output logic               out_border
`ifdef WIN3_FRAME_MARKERS_EN
  ,
  output logic               out_sof,
  output logic               out_eol,
  output logic               out_eof
`endif
);
  import win3_pkg::*;

  localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

  state_t state, state_nxt;

  logic [DIM_W-1:0] w_last, h_last;
  logic [DIM_W-1:0] col, row;
  logic [DIM_W-1:0] ecol, erow;
  logic             all_emitted;

  logic cfg_ok, start_ok, slot_free, out_take;
  logic in_acc, flush_step, step, emit;
  logic col_wrap, ecol_wrap, e_last, border_nxt;

  logic [PIX_W-1:0]   lb0_rd, lb1_rd, centre;
  logic [PIX_W-1:0]   arr [WIN_DIM][WIN_DIM];
  logic [PIX_W-1:0]   nxt [WIN_DIM][WIN_DIM];
  logic [9*PIX_W-1:0] win_nxt;

  assign cfg_ok = (cfg_width  >= DIM_W'(3)) && (cfg_width  <= DIM_W'(MAX_WIDTH)) &&
                  (cfg_height >= DIM_W'(3)) && (cfg_height <= DIM_W'(MAX_HEIGHT));
  assign start_ok = (state == IDLE) && start && cfg_ok;

  assign slot_free  = !out_valid || out_ready;
  assign out_take   = out_valid && out_ready;
  assign in_ready   = ((state == FILL) || (state == STREAM)) && slot_free;
  assign in_acc     = in_valid && in_ready;
  // Flush keeps stepping the window array along a virtual row so the last row's centres come out of lb0.
  assign flush_step = (state == FLUSH) && !all_emitted && slot_free;
  assign step       = in_acc || flush_step;
  assign emit       = ((state == STREAM) && in_acc) || flush_step;

  assign col_wrap   = (col == w_last);
  assign ecol_wrap  = (ecol == w_last);
  assign e_last     = (erow == h_last) && ecol_wrap;
  assign border_nxt = (erow == '0) || (erow == h_last) || (ecol == '0) || ecol_wrap;

  assign busy       = (state == FILL) || (state == STREAM) || (state == FLUSH);
  assign frame_done = (state == DONE);

  win3_line_buf #(.PIX_W(PIX_W), .DEPTH(MAX_WIDTH), .AW(AW)) lb0 (
    .clk     (clk),
    .wr_en   (in_acc),
    .wr_addr (col[AW-1:0]),
    .wr_data (in_pix),
    .rd_addr (col[AW-1:0]),
    .rd_data (lb0_rd)
  );

  win3_line_buf #(.PIX_W(PIX_W), .DEPTH(MAX_WIDTH), .AW(AW)) lb1 (
    .clk     (clk),
    .wr_en   (in_acc),
    .wr_addr (col[AW-1:0]),
    .wr_data (lb0_rd),
    .rd_addr (col[AW-1:0]),
    .rd_data (lb1_rd)
  );

  always_comb begin
    for (int i = 0; i < WIN_DIM; i++) begin
      nxt[i][0] = arr[i][1];
      nxt[i][1] = arr[i][2];
    end
    nxt[0][2] = lb1_rd;
    nxt[1][2] = lb0_rd;
    nxt[2][2] = in_pix;
  end

  // After the shift the middle cell is always the centre being emitted, including across column wrap.
  assign centre = nxt[1][1];

  always_comb begin
    win_nxt = '0;
    for (int i = 0; i < WIN_DIM; i++) begin
      for (int j = 0; j < WIN_DIM; j++) begin
        win_nxt[slot_idx(i, j)*PIX_W +: PIX_W] = border_nxt ? centre : nxt[i][j];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = FILL;
      FILL:    if (in_acc && (row == DIM_W'(1)) && (col == '0)) state_nxt = STREAM;
      STREAM:  if (in_acc && (row == h_last) && col_wrap) state_nxt = FLUSH;
      FLUSH:   if (all_emitted && out_take) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err     <= 1'b0;
      w_last      <= '0;
      h_last      <= '0;
      col         <= '0;
      row         <= '0;
      ecol        <= '0;
      erow        <= '0;
      all_emitted <= 1'b0;
    end else begin
      cfg_err <= (state == IDLE) && start && !cfg_ok;
      if (start_ok) begin
        w_last      <= cfg_width - DIM_W'(1);
        h_last      <= cfg_height - DIM_W'(1);
        col         <= '0;
        row         <= '0;
        ecol        <= '0;
        erow        <= '0;
        all_emitted <= 1'b0;
      end
      if (step) begin
        if (col_wrap) begin
          col <= '0;
          row <= row + DIM_W'(1);
        end else begin
          col <= col + DIM_W'(1);
        end
      end
      if (emit) begin
        if (ecol_wrap) begin
          ecol <= '0;
          erow <= erow + DIM_W'(1);
        end else begin
          ecol <= ecol + DIM_W'(1);
        end
        if (e_last) all_emitted <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIN_DIM; i++)
        for (int j = 0; j < WIN_DIM; j++)
          arr[i][j] <= '0;
    end else if (step) begin
      for (int i = 0; i < WIN_DIM; i++)
        for (int j = 0; j < WIN_DIM; j++)
          arr[i][j] <= nxt[i][j];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_win    <= '0;
      out_border <= 1'b0;
`ifdef WIN3_FRAME_MARKERS_EN
      out_sof    <= 1'b0;
      out_eol    <= 1'b0;
      out_eof    <= 1'b0;
`endif
    end else if (emit) begin
      out_valid  <= 1'b1;
      out_win    <= win_nxt;
      out_border <= border_nxt;
`ifdef WIN3_FRAME_MARKERS_EN
      out_sof    <= (erow == '0) && (ecol == '0);
      out_eol    <= ecol_wrap;
      out_eof    <= e_last;
`endif
    end else if (out_take) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_window_3x3_gen.sv
// Self-checking bench for window_3x3_gen: frame-level window model plus hand-computed spot values.
module tb_window_3x3_gen;
  localparam int PW = 8;
  localparam int MW = 512;
  localparam int MH = 512;
  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] cfg_width = '0;
  logic [DW-1:0] cfg_height = '0;
  logic          cfg_err, busy, frame_done;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] in_pix = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [9*PW-1:0] out_win;
  logic          out_border;
`ifdef WIN3_FRAME_MARKERS_EN
  logic          out_sof, out_eol, out_eof;
`endif

  always #5 clk = ~clk;

  window_3x3_gen #(.PIX_W(PW), .MAX_WIDTH(MW), .MAX_HEIGHT(MH), .DIM_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .cfg_err    (cfg_err),
    .busy       (busy),
    .frame_done (frame_done),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pix     (in_pix),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_win    (out_win),
    .out_border (out_border)
`ifdef WIN3_FRAME_MARKERS_EN
    ,
    .out_sof    (out_sof),
    .out_eol    (out_eol),
    .out_eof    (out_eof)
`endif
  );

  typedef struct {
    logic [9*PW-1:0] win;
    logic            bdr;
  } exp_t;

  exp_t            exp_q[$];
  logic [PW-1:0]   frame[$];
  logic [9*PW-1:0] got_win[$];
  logic            got_bdr[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int take_neg = 0;
  int done_neg = 0;
  int flush_takes = 0;
  bit after_last = 1'b0;
  bit rnd_rdy = 1'b0;
  bit prev_stall = 1'b0;
  logic [9*PW-1:0] prev_win;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Windows straight from the frame: border centres replicate, interior takes the 3x3 neighbourhood.
  function automatic void build_model(input int w, input int h);
    exp_q.delete();
    for (int idx = 0; idx < w * h; idx++) begin
      int r;
      int c;
      exp_t e;
      r = idx / w;
      c = idx % w;
      e.bdr = (r == 0) || (r == h - 1) || (c == 0) || (c == w - 1);
      for (int k = 0; k < 9; k++)
        e.win[k*PW +: PW] = e.bdr ? frame[idx] : frame[(r - 1 + k / 3) * w + (c - 1 + k % 3)];
      exp_q.push_back(e);
    end
  endfunction

  always @(posedge clk) cyc++;

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("hold_stable", {out_valid, out_win}, {1'b1, prev_win});
      if (out_valid && out_ready) begin
        check("window_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("win", out_win, e.win);
          check("border", out_border, e.bdr);
        end
        got_win.push_back(out_win);
        got_bdr.push_back(out_border);
        take_neg = cyc;
        if (after_last) flush_takes++;
      end
      prev_stall = out_valid && !out_ready;
      prev_win = out_win;
    end
  end

  task automatic start_frame(input int w, input int h);
    cfg_width = DW'(w);
    cfg_height = DW'(h);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_pixels(input int npix, input bit gaps, input int restart_at);
    for (int k = 0; k < npix; k++) begin
      bit ok;
      if (k == restart_at) begin
        in_valid = 1'b0;
        cfg_width = DW'(6);
        cfg_height = DW'(5);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_pix = frame[k];
      ok = 1'b0;
      for (int t = 0; t < 5000 && !ok; t++) begin
        @(negedge clk);
        if (in_ready) begin
          ok = 1'b1;
          @(posedge clk); #1;
        end
      end
      if (!ok) begin
        check("pixel_accept_timeout", ok, 1);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int nwin);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 20000 && !ok; t++) begin
      @(negedge clk);
      if (frame_done) ok = 1'b1;
    end
    check("frame_done_seen", ok, 1);
    done_neg = cyc;
    check("window_count", got_win.size(), nwin);
    check("model_drained", exp_q.size(), 0);
    @(negedge clk);
    check("done_pulse_busy_clear", {frame_done, busy}, 2'b00);
  endtask

  task automatic run_frame(input int w, input int h, input bit gaps, input bit rnd,
                           input int restart_at, input bit seq_pix);
    frame.delete();
    for (int k = 0; k < w * h; k++)
      frame.push_back(seq_pix ? PW'(k + 1) : PW'($urandom_range(0, 255)));
    got_win.delete();
    got_bdr.delete();
    after_last = 1'b0;
    flush_takes = 0;
    build_model(w, h);
    rnd_rdy = rnd;
    start_frame(w, h);
    @(negedge clk);
    check("busy_after_start", busy, 1);
    @(posedge clk); #1;
    send_pixels(w * h, gaps, restart_at);
    after_last = 1'b1;
    wait_done(w * h);
    rnd_rdy = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int errs;
    bit busy_seen;
    bit rdy_seen;
    logic [9*PW-1:0] v;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {cfg_err, busy, frame_done, in_ready, out_valid, out_border, out_win}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 3x3 ramp: only the centre window is interior.
    run_frame(3, 3, 1'b0, 1'b0, -1, 1'b1);
    v = 72'h09_08_07_06_05_04_03_02_01;
    check("t1_win4", got_win[4], v);
    check("t1_bdr4", got_bdr[4], 0);
    v = {9{8'h01}};
    check("t1_win0", got_win[0], v);
    check("t1_bdr0", got_bdr[0], 1);
    v = {9{8'h06}};
    check("t1_win5", got_win[5], v);
    v = {9{8'h09}};
    check("t1_win8", got_win[8], v);
    check("t1_done_latency", done_neg - take_neg, 1);

    // Illegal width and illegal height.
    for (int n = 0; n < 2; n++) begin
      @(posedge clk); #1;
      start_frame(n == 0 ? 2 : 4, n == 0 ? 8 : 513);
      errs = 0;
      busy_seen = 1'b0;
      rdy_seen = 1'b0;
      for (int t = 0; t < 6; t++) begin
        @(negedge clk);
        errs += int'(cfg_err);
        busy_seen |= busy;
        rdy_seen |= in_ready;
      end
      check("cfg_err_pulses", errs, 1);
      check("cfg_busy", busy_seen, 0);
      check("cfg_in_ready", rdy_seen, 0);
      @(posedge clk); #1;
    end

    // 5 wide by 4 high, random data, input gaps and output stalls.
    run_frame(5, 4, 1'b1, 1'b1, -1, 1'b0);

    // Mid-frame start with another legal size is ignored.
    run_frame(4, 3, 1'b0, 1'b1, 5, 1'b0);

    // Reset mid-frame after 7 pixels, then a clean frame.
    frame.delete();
    for (int k = 0; k < 16; k++) frame.push_back(PW'($urandom_range(0, 255)));
    got_win.delete();
    got_bdr.delete();
    build_model(4, 4);
    start_frame(4, 4);
    send_pixels(7, 1'b0, -1);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mid_reset_outputs", {cfg_err, busy, frame_done, in_ready, out_valid, out_border, out_win}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", {busy, in_ready, out_valid}, 3'b000);
    @(posedge clk); #1;
    run_frame(4, 4, 1'b1, 1'b1, -1, 1'b0);

    // Maximum width: flush yields W+1 windows after the one from the last pixel.
    run_frame(512, 3, 1'b0, 1'b0, -1, 1'b0);
    check("t6_flush_takes", flush_takes, 512 + 2);
    v = {9{frame[1535]}};
    check("t6_last_window", got_win[got_win.size() - 1], v);
    check("t6_last_border", got_bdr[got_bdr.size() - 1], 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
